instr_fetch_mem: RTL and testbench

//  Parametrised, pipelined instruction memory with valid/ready request and response channels.

---
 rtl/riswitch_mem_pkg.sv | 17 +
 rtl/instr_rsp_fifo.sv | 55 +++++
 rtl/instr_fetch_mem.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riswitch_mem_pkg.sv
// Shared types for the instruction fetch memory: the response record carried
// through the read pipeline and the response buffer, and the fault NOP.
package riswitch_mem_pkg;

    localparam int unsigned RSP_ADDR_W  = 32;
    localparam int unsigned RSP_INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [RSP_INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [RSP_INSTR_W-1:0] instr;
        logic [RSP_ADDR_W-1:0]  addr;
        logic                   fault;
    } fetch_rsp_t;

endpackage

// File: rtl/instr_rsp_fifo.sv
// Response buffer: synchronous FIFO of fetch responses, any depth >= 1,
// with a synchronous clear used by the fetch flush path.
module instr_rsp_fifo
    import riswitch_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  fetch_rsp_t push_data,
    input  logic       pop,
    output fetch_rsp_t head,
    output logic       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_rsp_t       entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = entries[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction memory with valid/ready fetch channels, credit-limited
// outstanding requests, flush, fault reporting and a runtime load port.
module instr_fetch_mem
    import riswitch_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INSTR_W    = 32,
    parameter int unsigned       DEPTH      = 131072,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       LATENCY    = 1,
    parameter int unsigned       RESP_DEPTH = 2,
    // Kept for interface compatibility; the program image is written through the load port.
    parameter string             INIT_FILE  = ""
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic               rsp_fault,
    input  logic               flush,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic             fault;
        logic [IDX_W-1:0] idx;
    } decode_t;

    // Offset and range check are done at full address width so out-of-range
    // addresses never alias onto a valid word.
    function automatic decode_t decode(input logic [ADDR_W-1:0] a);
        decode_t           d;
        logic [ADDR_W:0]   diff;
        logic [ADDR_W-1:0] word;
        diff    = {1'b0, a} - {1'b0, BASE_ADDR};
        word    = diff[ADDR_W-1:0] >> 2;
        d.fault = (a[1:0] != 2'b00) || diff[ADDR_W] || (word >= ADDR_W'(DEPTH));
        d.idx   = word[IDX_W-1:0];
        return d;
    endfunction

    logic [INSTR_W-1:0] mem [DEPTH];
    decode_t            req_dec;
    decode_t            load_dec;
    logic               accept;
    logic [LATENCY:0]   stage_valid;
    fetch_rsp_t         stage_data [LATENCY+1];
    logic [CNT_W-1:0]   outstanding;
    fetch_rsp_t         fifo_head;
    fetch_rsp_t         out_rsp;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               out_valid;
    logic               rsp_fire;

    assign req_dec   = decode(req_addr);
    assign load_dec  = decode(load_addr);
    assign req_ready = !flush && (outstanding < CNT_W'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (load_en && !load_dec.fault) begin
            mem[load_dec.idx] <= load_data;
        end
    end

    // Stage 0 samples the array on the accept edge, so a load to the same word
    // in that cycle is not yet visible (read-first).
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            stage_valid <= '0;
        end else begin
            stage_valid <= {stage_valid[LATENCY-1:0], accept};
        end
        if (accept) begin
            stage_data[0] <= '{
                instr: req_dec.fault ? INSTR_NOP : RSP_INSTR_W'(mem[req_dec.idx]),
                addr:  RSP_ADDR_W'(req_addr),
                fault: req_dec.fault
            };
        end
        for (int unsigned i = 1; i <= LATENCY; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
    end

    // Last stage is shown directly while the buffer is empty; anything not
    // taken that cycle is parked in the buffer so the outputs stay stable.
    always_comb begin
        out_valid = fifo_empty ? stage_valid[LATENCY] : 1'b1;
        out_rsp   = fifo_empty ? stage_data[LATENCY] : fifo_head;
        if (!out_valid) begin
            out_rsp = '0;
        end
        rsp_fire  = out_valid && rsp_ready;
        fifo_pop  = !fifo_empty && rsp_ready;
        fifo_push = stage_valid[LATENCY] && !(fifo_empty && rsp_ready);
    end

    instr_rsp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (stage_data[LATENCY]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            outstanding <= '0;
        end else begin
            case ({accept, rsp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign rsp_valid = out_valid;
    assign rsp_instr = INSTR_W'(out_rsp.instr);
    assign rsp_addr  = ADDR_W'(out_rsp.addr);
    assign rsp_fault = out_rsp.fault;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed vector table, hand-written
// back-pressure/flush/reset/load sequences, and a randomized run against a queue model.
module tb_instr_fetch_mem;

    localparam int unsigned L   = 3;
    localparam int unsigned RD  = 2;
    localparam int unsigned D   = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        req_ready,  rsp_valid,  rsp_fault;
    logic [31:0] rsp_instr,  rsp_addr;
    logic        req_ready1, rsp_valid1, rsp_fault1;
    logic [31:0] rsp_instr1, rsp_addr1;

    instr_fetch_mem #(
        .ADDR_W (32), .INSTR_W (32), .DEPTH (D), .BASE_ADDR (32'h0),
        .LATENCY (L), .RESP_DEPTH (RD), .INIT_FILE ("")
    ) dut (
        .clock (clock), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_instr (rsp_instr),
        .rsp_addr (rsp_addr), .rsp_fault (rsp_fault), .flush (flush),
        .load_en (load_en), .load_addr (load_addr), .load_data (load_data)
    );

    instr_fetch_mem #(
        .ADDR_W (32), .INSTR_W (32), .DEPTH (D), .BASE_ADDR (32'h0),
        .LATENCY (1), .RESP_DEPTH (RD), .INIT_FILE ("")
    ) dut_l1 (
        .clock (clock), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready1), .req_addr (req_addr),
        .rsp_valid (rsp_valid1), .rsp_ready (rsp_ready), .rsp_instr (rsp_instr1),
        .rsp_addr (rsp_addr1), .rsp_fault (rsp_fault1), .flush (flush),
        .load_en (load_en), .load_addr (load_addr), .load_data (load_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mm [D];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int unsigned rdy_cyc;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic m_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= D);
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        return m_fault(a) ? NOP : mm[a / 4];
    endfunction

    task automatic issue(input logic [31:0] a);
        int unsigned waited;
        req_valid = 1'b1;
        req_addr  = a;
        waited    = 0;
        #1;
        while (!req_ready && waited < 30) begin
            tick();
            waited++;
        end
        chk("issue_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] ri, output logic [31:0] ra,
                            output logic rf, output int lat);
        lat = -1;
        ri  = '0;
        ra  = '0;
        rf  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (rsp_valid) begin
                ri  = rsp_instr;
                ra  = rsp_addr;
                rf  = rsp_fault;
                lat = c;
                break;
            end
        end
    endtask

    task automatic fetch_check(input string name, input logic [31:0] a,
                               input logic [31:0] ei, input logic ef);
        logic [31:0] ri, ra;
        logic        rf;
        int          lat;
        rsp_ready = 1'b1;
        issue(a);
        wait_rsp(ri, ra, rf, lat);
        chk({name, "_latency"}, 32'(lat), 32'(L));
        chk({name, "_instr"}, ri, ei);
        chk({name, "_addr"}, ra, a);
        chk({name, "_fault"}, 32'(rf), 32'(ef));
    endtask

    task automatic quiet_check(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog expired");
    end

    vec_t        vecs [9];
    exp_t        q [$];
    logic [31:0] got_a [$];
    logic [31:0] got_i [$];

    initial begin
        logic [31:0] ri, ra, h_i, h_a, v;
        logic        rf, exp_valid, acc_now, do_acc;
        int          lat, lat1;
        int unsigned cyc, accepted, sz, r;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        chk("reset_rsp_addr", rsp_addr, 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);

        for (int unsigned i = 0; i < D; i++) begin
            v = (i == 0) ? 32'h0050_0093 : (i == D - 1) ? 32'hCAFE_F00D
                : (32'h1000_0000 ^ (i * 32'h0101_0103));
            load_en = 1'b1; load_addr = i * 4; load_data = v;
            mm[i] = v;
            tick();
        end
        load_en = 1'b0;

        // Accept-to-valid latency on both pipeline depths.
        rsp_ready = 1'b1;
        issue(32'h0);
        lat = -1; lat1 = -1; ri = '0; h_i = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (rsp_valid1 && lat1 < 0) begin lat1 = c; h_i = rsp_instr1; end
            if (rsp_valid && lat < 0) begin lat = c; ri = rsp_instr; end
        end
        chk("lat1_cycles", 32'(lat1), 32'd1);
        chk("lat1_instr", h_i, 32'h0050_0093);
        chk("lat3_cycles", 32'(lat), 32'd3);
        chk("lat3_instr", ri, 32'h0050_0093);

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0010, mm[4], 1'b0};
        vecs[2] = '{32'h0000_0002, NOP, 1'b1};
        vecs[3] = '{32'(4 * D), NOP, 1'b1};
        vecs[4] = '{32'(4 * (D - 1)), 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{32'h0001_0000, NOP, 1'b1};
        vecs[6] = '{32'hFFFF_FFFC, NOP, 1'b1};
        vecs[7] = '{32'h0000_0003, NOP, 1'b1};
        vecs[8] = '{32'h0000_007C, mm[31], 1'b0};
        foreach (vecs[i]) begin
            fetch_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].fault);
        end

        // Back-pressure: third request blocked by credits, outputs held while stalled.
        tick(); tick();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0; #1;
        chk("bp_ready0", 32'(req_ready), 32'd1);
        tick();
        req_addr = 32'h4; #1;
        chk("bp_ready1", 32'(req_ready), 32'd1);
        tick();
        req_addr = 32'h8; #1;
        chk("bp_ready2_blocked", 32'(req_ready), 32'd0);
        repeat (L + 3) tick();
        h_i = rsp_instr; h_a = rsp_addr;
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_addr", h_a, 32'h0);
        chk("bp_hold_instr", h_i, mm[0]);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_stable_addr", rsp_addr, h_a);
            chk("bp_stable_instr", rsp_instr, h_i);
        end
        chk("bp_still_blocked", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        got_a.delete(); got_i.delete();
        for (int c = 0; c < 30 && got_a.size() < 3; c++) begin
            if (rsp_valid) begin
                got_a.push_back(rsp_addr);
                got_i.push_back(rsp_instr);
            end
            acc_now = req_valid && req_ready;
            tick();
            if (acc_now) req_valid = 1'b0;
        end
        chk("bp_count", 32'(got_a.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (got_a.size() > i) begin
                chk($sformatf("bp_order%0d_addr", i), got_a[i], 32'(4 * i));
                chk($sformatf("bp_order%0d_instr", i), got_i[i], mm[i]);
            end
        end
        req_valid = 1'b0;

        // Flush with two requests still in the pipeline.
        tick(); tick();
        rsp_ready = 1'b1;
        issue(32'h0);
        issue(32'h4);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10; #1;
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        quiet_check("flush_no_rsp", 8);
        fetch_check("after_flush", 32'h10, mm[4], 1'b0);

        // Flush while the response buffer holds entries.
        tick(); tick();
        rsp_ready = 1'b0;
        issue(32'h40);
        issue(32'h44);
        repeat (L + 2) tick();
        chk("flushbuf_full", 32'(rsp_valid), 32'd1);
        flush = 1'b1; #1;
        tick();
        flush = 1'b0; #1;
        chk("flushbuf_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flushbuf_req_ready", 32'(req_ready), 32'd1);
        quiet_check("flushbuf_no_rsp", 6);

        // Load and fetch of the same word in one cycle: old data first.
        rsp_ready = 1'b1;
        load_en = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
        issue(32'h20);
        load_en = 1'b0;
        wait_rsp(ri, ra, rf, lat);
        chk("rfirst_old", ri, mm[8]);
        mm[8] = 32'hDEAD_BEEF;
        fetch_check("rfirst_new", 32'h20, 32'hDEAD_BEEF, 1'b0);
        load_en = 1'b1; load_addr = 32'h22; load_data = 32'h1111_1111;
        tick();
        load_addr = 32'h0001_0000; load_data = 32'h2222_2222;
        tick();
        load_en = 1'b0;
        fetch_check("load_misaligned_dropped", 32'h20, 32'hDEAD_BEEF, 1'b0);
        fetch_check("load_range_dropped", 32'h0, 32'h0050_0093, 1'b0);

        // Reset with the response buffer full.
        tick(); tick();
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        repeat (L + 2) tick();
        chk("rst_buf_full", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_addr", rsp_addr, 32'd0);
        quiet_check("rst_no_rsp", 6);

        // Randomized run against an in-order queue model with credit and latency rules.
        q.delete();
        cyc = 0;
        accepted = 0;
        while (accepted < 10000 && cyc < 60000) begin
            req_valid = ($urandom_range(0, 99) < 75);
            r = $urandom_range(0, 99);
            if (r < 80)      req_addr = 4 * $urandom_range(0, 63);
            else if (r < 88) req_addr = 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else if (r < 94) req_addr = 4 * D + 4 * $urandom_range(0, 255);
            else             req_addr = $urandom;
            rsp_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 999) < 5);
            load_en   = ($urandom_range(0, 99) < 10);
            r = $urandom_range(0, 99);
            if (r < 85)      load_addr = 4 * $urandom_range(0, 63);
            else if (r < 93) load_addr = 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else             load_addr = 4 * D + 4 * $urandom_range(0, 15);
            load_data = $urandom;
            #1;
            sz = q.size();
            exp_valid = (sz > 0) && (cyc >= q[0].rdy_cyc);
            chk("rnd_req_ready", 32'(req_ready), 32'(!flush && sz < RD));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rnd_rsp_instr", rsp_instr, q[0].instr);
                chk("rnd_rsp_addr", rsp_addr, q[0].addr);
                chk("rnd_rsp_fault", 32'(rsp_fault), 32'(q[0].fault));
            end
            if (exp_valid && rsp_ready) void'(q.pop_front());
            do_acc = req_valid && !flush && (sz < RD);
            if (do_acc) begin
                q.push_back('{req_addr, m_instr(req_addr), m_fault(req_addr), cyc + 1 + L});
                accepted++;
            end
            if (flush) q.delete();
            if (load_en && !m_fault(load_addr)) mm[load_addr / 4] = load_data;
            tick();
            cyc++;
        end
        req_valid = 1'b0; flush = 1'b0; load_en = 1'b0;
        chk("rnd_completed", 32'(accepted >= 10000), 32'd1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
